// File: rtl/pulse_width_modulator_if.sv
// Bundle of the PWM control inputs and the generated waveform.
// The controller drives period/duty selects; the PWM block returns SIGNAL.
interface pulse_width_modulator_if;
  logic [7:0] FREQ;
  logic [7:0] DUTY_CYCLE;
  logic       SIGNAL;

  modport master (
    output FREQ,
    output DUTY_CYCLE,
    input  SIGNAL
  );

  modport slave (
    input  FREQ,
    input  DUTY_CYCLE,
    output SIGNAL
  );
endinterface

// File: rtl/pulse_width_modulator.sv
// 8-bit PWM generator: a prescaler stretches each of 256 phases to FREQ+1 clocks.
// FREQ/DUTY_CYCLE are shadowed and only take effect at period boundaries.
module pulse_width_modulator (
  input  logic                            CLK,
  input  logic                            RSTB,
  pulse_width_modulator_if.slave          pwm
);

  logic [7:0] pre_cnt_r;
  logic [7:0] phase_r;
  logic [7:0] freq_q_r;
  logic [7:0] duty_q_r;
  logic       primed_r;
  logic       signal_r;

  logic [7:0] pre_cnt_s;
  logic [7:0] phase_s;
  logic [7:0] freq_q_s;
  logic [7:0] duty_q_s;
  logic       primed_s;
  logic       signal_s;

  // Next-state: priming load, prescaler/phase advance, boundary reload of shadows.
  always_comb begin
    pre_cnt_s = pre_cnt_r;
    phase_s   = phase_r;
    freq_q_s  = freq_q_r;
    duty_q_s  = duty_q_r;
    primed_s  = primed_r;
    if (!primed_r) begin
      pre_cnt_s = 8'd0;
      phase_s   = 8'd0;
      freq_q_s  = pwm.FREQ;
      duty_q_s  = pwm.DUTY_CYCLE;
      primed_s  = 1'b1;
    end else if (pre_cnt_r == freq_q_r) begin
      pre_cnt_s = 8'd0;
      phase_s   = phase_r + 8'd1;
      if (phase_r == 8'hFF) begin
        freq_q_s = pwm.FREQ;
        duty_q_s = pwm.DUTY_CYCLE;
      end else begin
        freq_q_s = freq_q_r;
        duty_q_s = duty_q_r;
      end
    end else begin
      pre_cnt_s = pre_cnt_r + 8'd1;
      phase_s   = phase_r;
    end
    // Compare against the values being loaded so output tracks the same edge.
    signal_s = (duty_q_s != 8'd0) && (phase_s <= duty_q_s);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pre_cnt_r <= 8'd0;
      phase_r   <= 8'd0;
      freq_q_r  <= 8'd0;
      duty_q_r  <= 8'd0;
      primed_r  <= 1'b0;
      signal_r  <= 1'b0;
    end else begin
      pre_cnt_r <= pre_cnt_s;
      phase_r   <= phase_s;
      freq_q_r  <= freq_q_s;
      duty_q_r  <= duty_q_s;
      primed_r  <= primed_s;
      signal_r  <= signal_s;
    end
  end

  assign pwm.SIGNAL = signal_r;

endmodule

// File: tb/tb_pulse_width_modulator.sv
// Directed bench for pulse_width_modulator: measures high/low time per period
// against hand-computed values and checks asynchronous reset behaviour.
module tb_pulse_width_modulator;

  logic clk;
  logic rstb;
  int   n_cmp;
  int   n_err;

  pulse_width_modulator_if pwm_bus ();

  pulse_width_modulator dut (
    .CLK  (clk),
    .RSTB (rstb),
    .pwm  (pwm_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset with given inputs, release on a falling edge; next rising edge primes.
  task automatic do_reset(input string tag, input logic [7:0] f, input logic [7:0] d);
    rstb = 1'b0;
    pwm_bus.FREQ = f;
    pwm_bus.DUTY_CYCLE = d;
    repeat (2) @(negedge clk);
    check_val({tag, "_in_reset"}, int'(pwm_bus.SIGNAL), 0);
    rstb = 1'b1;
    #1;
    check_val({tag, "_pre_prime"}, int'(pwm_bus.SIGNAL), 0);
  endtask

  // One period: first hi samples must be high, next lo samples low.
  task automatic period_check(input string tag, input int hi, input int lo,
                              input int chg_at, input logic [7:0] chg_val);
    int hi_seen;
    int lo_seen;
    hi_seen = 0;
    lo_seen = 0;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (i == chg_at) pwm_bus.DUTY_CYCLE = chg_val;
      if (i < hi && pwm_bus.SIGNAL) hi_seen++;
      if (i >= hi && !pwm_bus.SIGNAL) lo_seen++;
    end
    check_val({tag, "_high"}, hi_seen, hi);
    check_val({tag, "_low"}, lo_seen, lo);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstb = 1'b0;
    pwm_bus.FREQ = 8'h00;
    pwm_bus.DUTY_CYCLE = 8'h00;

    // 50% at full rate
    do_reset("d7f", 8'h00, 8'h7F);
    period_check("d7f_p1", 128, 128, -1, 8'h00);
    period_check("d7f_p2", 128, 128, -1, 8'h00);

    // 75% with FREQ=2 (3 clocks per phase)
    do_reset("f2", 8'h02, 8'hBF);
    period_check("f2_p1", 576, 192, -1, 8'h00);
    period_check("f2_p2", 576, 192, -1, 8'h00);

    // 25%
    do_reset("d3f", 8'h00, 8'h3F);
    period_check("d3f_p1", 64, 192, -1, 8'h00);

    // duty zero never high
    do_reset("d00", 8'h00, 8'h00);
    period_check("d00_p1", 0, 256, -1, 8'h00);
    period_check("d00_p2", 0, 256, -1, 8'h00);

    // full duty stays high across the wrap
    do_reset("dff", 8'h00, 8'hFF);
    period_check("dff_p1", 256, 0, -1, 8'h00);
    period_check("dff_p2", 256, 0, -1, 8'h00);

    // duty change mid-period only takes effect at the boundary
    do_reset("chg", 8'h00, 8'h7F);
    period_check("chg_p1", 128, 128, 50, 8'h3F);
    period_check("chg_p2", 64, 192, -1, 8'h00);

    // asynchronous reset during the high phase
    do_reset("arst", 8'h00, 8'h7F);
    repeat (20) @(negedge clk);
    check_val("arst_high_before", int'(pwm_bus.SIGNAL), 1);
    #1;
    rstb = 1'b0;
    #1;
    check_val("arst_drop_no_edge", int'(pwm_bus.SIGNAL), 0);

    // re-prime picks up inputs present at release
    do_reset("reprime", 8'h01, 8'h3F);
    period_check("reprime_p1", 128, 384, -1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
